wb_traffic_gen: RTL
===================

WB_TRAFFIC_GEN -- requirements
Module: wb_traffic_gen

Interface
REQ-001 SHALL have parameter APP_AW, default 26, Wishbone byte-address width.
REQ-002 SHALL have parameter APP_DW, default 32, Wishbone data width; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter APP_BW, default APP_DW/8, number of byte-select bits.
REQ-004 SHALL have parameter MAX_BL, default 16, maximum number of beats per burst.
REQ-005 SHALL have parameter CNT_W, default 16, width of the burst and error counters.
REQ-006 SHALL have the following ports, one per line as name / direction / width / meaning:
- wb_clk_i / in / 1 / single clock; all state changes on its rising edge.
- wb_rst_i / in / 1 / reset; asynchronous assert, active-low.
- sdr_init_done / in / 1 / SDRAM controller initialisation complete.
- start / in / 1 / one-cycle request to begin a run.
- cfg_base_addr / in / APP_AW / first byte address of the run.
- cfg_bl / in / clog2(MAX_BL)+1 / beats per burst.
- cfg_num_bursts / in / CNT_W / number of write+readback burst pairs.
- cfg_seed / in / 32 / initial LFSR value.
- wb_cyc_o / out / 1 / Wishbone cycle.
- wb_stb_o / out / 1 / Wishbone strobe.
- wb_we_o / out / 1 / Wishbone write enable.
- wb_addr_o / out / APP_AW / Wishbone address.
- wb_dat_o / out / APP_DW / write data.
- wb_sel_o / out / APP_BW / byte selects.
- wb_cti_o / out / 3 / cycle type identifier.
- wb_ack_i / in / 1 / Wishbone acknowledge.
- wb_dat_i / in / APP_DW / read data.
- busy / out / 1 / run in progress.
- done / out / 1 / one-cycle pulse at end of run.
- err_cnt / out / CNT_W / number of readback mismatches.
- first_err_addr / out / APP_AW / address of the first mismatch.

Function
REQ-007 SHALL implement states IDLE, WAIT_INIT, WR, RD and FIN.
REQ-008 SHALL, in IDLE on start=1, latch all cfg_* inputs, clear err_cnt and first_err_addr, and go to WAIT_INIT; start in any other state SHALL be ignored.
REQ-009 SHALL leave WAIT_INIT for WR when sdr_init_done=1, or for FIN when the latched cfg_num_bursts=0.
REQ-010 SHALL hold busy=1 in every state except IDLE.
REQ-011 SHALL treat latched cfg_bl=0 as 1 and cfg_bl>MAX_BL as MAX_BL.
REQ-012 SHALL, in WR and RD, hold wb_cyc_o=wb_stb_o=1 with address and data stable until wb_ack_i=1; one ack completes one beat.
REQ-013 SHALL ignore wb_ack_i whenever wb_stb_o=0.
REQ-014 SHALL drive wb_sel_o to all ones, wb_we_o=1 in WR and wb_we_o=0 in RD.
REQ-015 SHALL advance the beat address by APP_BW on each ack, wrapping modulo 2^APP_AW.
REQ-016 SHALL use as data source a 32-bit Galois LFSR (x^32+x^22+x^2+x+1); beat data is LFSR[APP_DW-1:0], and the LFSR steps once per acked beat.
REQ-017 SHALL, after the last WR beat is acked, enter RD at that burst's start address with the LFSR restored to its value at burst start.
REQ-018 SHALL, on each RD ack, compare wb_dat_i with the expected data; on mismatch it SHALL increment err_cnt (saturating at all ones) and, on the first mismatch only, capture the beat address into first_err_addr.
REQ-019 SHALL, after the last RD beat, go to WR at the next sequential address if bursts remain, otherwise go to FIN; the next burst continues the LFSR sequence.
REQ-020 SHALL, in FIN, pulse done=1 for exactly one cycle and return to IDLE in the next cycle.
REQ-021 SHALL deassert wb_cyc_o and wb_stb_o for at least one cycle between a WR burst and its RD burst, and between consecutive bursts.
REQ-022 SHALL assert wb_cyc_o the cycle after the state register enters WR or RD.

Reset
REQ-023 SHALL, while wb_rst_i=0, immediately force the state to IDLE and all outputs to 0, independent of the clock.
REQ-024 SHALL abandon an in-flight cycle when reset asserts mid-run, with no done pulse, and SHALL keep err_cnt at 0 after reset.

Configuration
REQ-025 SHALL use macro WBTG_CTI_BURST_EN to select burst signalling.
REQ-026 SHALL, with WBTG_CTI_BURST_EN defined, drive wb_cti_o=3'b010 on every beat except the last, drive 3'b111 on the last beat, and hold wb_cyc_o high for the whole burst.
REQ-027 SHALL, without WBTG_CTI_BURST_EN, drive wb_cti_o=3'b000 and deassert wb_cyc_o and wb_stb_o for one cycle after every ack (classic single cycles).

Verification
REQ-028 SHALL cover: seed=32'h1, base=0, bl=4, bursts=2, memory model correct -> 8 writes and 8 reads, addresses 0..28 step 4, done pulse, err_cnt=0.
REQ-029 SHALL cover: same run with memory bit 0 flipped at address 0x8 -> err_cnt=1, first_err_addr=0x8.
REQ-030 SHALL cover: bursts=0 -> done exactly one cycle after leaving WAIT_INIT, with no wb_cyc_o activity.
REQ-031 SHALL cover: base=2^26-8, bl=4 -> addresses 0x3FFFFF8, 0x3FFFFFC, 0x0, 0x4.
REQ-032 SHALL cover: wb_rst_i low in the middle of the second WR beat -> wb_cyc_o=0 and busy=0 immediately, with no done pulse.
REQ-033 SHALL cover: with the macro defined and bl=4, wb_cti_o sequence 010,010,010,111; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/wb_traffic_gen_if.sv
// Wishbone master bus bundle used by wb_traffic_gen.
interface wb_traffic_gen_if #(
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int APP_BW = APP_DW/8
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [APP_DW-1:0] wb_dat_o;
  logic [APP_BW-1:0] wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic              wb_ack_i;
  logic [APP_DW-1:0] wb_dat_i;

  modport master (output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                  input  wb_ack_i, wb_dat_i);
  modport slave  (input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                  output wb_ack_i, wb_dat_i);
endinterface

// File: rtl/wb_traffic_gen.sv
// Wishbone write/readback traffic generator: LFSR-patterned bursts are written, read back
// and checked. Define WBTG_CTI_BURST_EN for incrementing-burst cycles instead of classic.
module wb_traffic_gen #(
  parameter int APP_AW = 26,
  parameter int APP_DW = 32,
  parameter int APP_BW = APP_DW/8,
  parameter int MAX_BL = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    sdr_init_done,
  input  logic                    start,
  input  logic [APP_AW-1:0]       cfg_base_addr,
  input  logic [$clog2(MAX_BL):0] cfg_bl,
  input  logic [CNT_W-1:0]        cfg_num_bursts,
  input  logic [31:0]             cfg_seed,
  wb_traffic_gen_if.master        wb,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [APP_AW-1:0]       first_err_addr
);
  localparam int          BLW       = $clog2(MAX_BL) + 1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003; // x^32+x^22+x^2+x+1, right-shifting Galois
`ifdef WBTG_CTI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WAIT_INIT, WR, RD, FIN} state_e;
  state_e state_q, state_d;

  logic [BLW-1:0]    bl_q, beat_q, bl_cfg;
  logic [CNT_W-1:0]  nb_q;
  logic [APP_AW-1:0] addr_q, burst_addr_q, addr_inc;
  logic [31:0]       lfsr_q, lfsr_start_q, lfsr_nxt;
  logic              cyc_q, beat_ack, last_beat, rd_miss;

  assign bl_cfg    = (cfg_bl == '0) ? BLW'(1) : (cfg_bl > BLW'(MAX_BL)) ? BLW'(MAX_BL) : cfg_bl;
  assign beat_ack  = cyc_q & wb.wb_ack_i;
  assign last_beat = (beat_q == bl_q - BLW'(1));
  assign addr_inc  = addr_q + APP_AW'(APP_BW);
  assign lfsr_nxt  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign rd_miss   = (wb.wb_dat_i != lfsr_q[APP_DW-1:0]);

  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = cyc_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_dat_o  = lfsr_q[APP_DW-1:0];
  assign wb.wb_sel_o  = {APP_BW{cyc_q}};

  always_ff @(posedge wb_clk_i or negedge wb_rst_i)
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    wb.wb_we_o  = 1'b0;
    wb.wb_cti_o = 3'b000;
    case (state_q)
      IDLE:      if (start) state_d = WAIT_INIT;
      WAIT_INIT: if (nb_q == '0)        state_d = FIN;
                 else if (sdr_init_done) state_d = WR;
      WR: begin
        wb.wb_we_o = 1'b1;
        if (beat_ack && last_beat) state_d = RD;
      end
      RD:  if (beat_ack && last_beat) state_d = (nb_q > CNT_W'(1)) ? WR : FIN;
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (BURST && cyc_q) wb.wb_cti_o = last_beat ? 3'b111 : 3'b010;
  end

  // cyc is registered, so it rises one cycle after entering WR/RD; that cycle is the
  // mandatory idle gap between a write burst, its readback, and the next burst.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      cyc_q          <= 1'b0;
      bl_q           <= '0;
      beat_q         <= '0;
      nb_q           <= '0;
      addr_q         <= '0;
      burst_addr_q   <= '0;
      lfsr_q         <= '0;
      lfsr_start_q   <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          bl_q           <= bl_cfg;
          nb_q           <= cfg_num_bursts;
          addr_q         <= cfg_base_addr;
          burst_addr_q   <= cfg_base_addr;
          lfsr_q         <= cfg_seed;
          lfsr_start_q   <= cfg_seed;
          beat_q         <= '0;
          err_cnt        <= '0;
          first_err_addr <= '0;
        end
        WR, RD: begin
          if (!cyc_q) cyc_q <= 1'b1;
          else if (beat_ack) begin
            cyc_q  <= BURST && !last_beat;
            lfsr_q <= lfsr_nxt;
            addr_q <= addr_inc;
            beat_q <= beat_q + BLW'(1);
            if (state_q == RD && rd_miss) begin
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
              if (err_cnt == '0) first_err_addr <= addr_q;
            end
            if (last_beat) begin
              beat_q <= '0;
              if (state_q == WR) begin
                // replay the same burst for readback
                addr_q <= burst_addr_q;
                lfsr_q <= lfsr_start_q;
              end else begin
                nb_q         <= nb_q - CNT_W'(1);
                burst_addr_q <= addr_inc;
                lfsr_start_q <= lfsr_nxt;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
